// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : UART receive-side controller with a show-ahead byte FIFO, receiver
//            flow control and sticky error status. Optional irq output when
//            UART_RXC_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int SIZE      = 8,
    parameter int DEPTH     = 4,
    parameter int AW        = 2
`ifdef UART_RXC_IRQ_EN
    ,
    parameter int IRQ_LEVEL = 1
`endif
) (
    input  logic            sample_clock,
    input  logic            resetn,
    input  logic [SIZE-1:0] rx_data,
    input  logic            rx_done,
    input  logic            rx_err1,
    input  logic            rx_err2,
    output logic            rx_busy,
    input  logic            host_rd,
    output logic [SIZE-1:0] host_data,
    output logic            host_empty,
    output logic [AW:0]     host_count,
    output logic            err_ovr,
    output logic            err_frm,
`ifdef UART_RXC_IRQ_EN
    output logic            irq,
`endif
    input  logic            err_clr
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    localparam logic [AW:0] c_full   = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_almost = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] c_one    = (AW+1)'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SIZE-1:0]   r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [AW:0]       w_count_nxt;
    logic              r_err_ovr;
    logic              r_err_frm;
    logic              w_ovr_nxt;
    logic              w_frm_nxt;
    logic              w_wr;
    logic              w_rd;

    always_comb begin
        w_state_nxt = r_state;
        w_ovr_nxt   = err_clr ? 1'b0 : r_err_ovr;
        w_frm_nxt   = err_clr ? 1'b0 : r_err_frm;
        w_wr        = 1'b0;
        w_rd        = host_rd && (r_count != '0);
        case (r_state)
            ST_IDLE: begin
                // overrun outranks framing; only a clean frame is captured
                if (rx_done) begin
                    if (rx_err1)      w_ovr_nxt   = 1'b1;
                    else if (rx_err2) w_frm_nxt   = 1'b1;
                    else              w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_wr        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        case ({w_wr, w_rd})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge sample_clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_ovr <= 1'b0;
            r_err_frm <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_err_ovr <= w_ovr_nxt;
            r_err_frm <= w_frm_nxt;
            if (w_wr) begin
                r_mem[r_wr_ptr] <= rx_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

`ifdef UART_RXC_IRQ_EN
    localparam logic [AW:0] c_irq_level = (AW+1)'(IRQ_LEVEL);
    logic r_irq;

    // computed from next-state values so irq moves with the count/flags
    always_ff @(posedge sample_clock or negedge resetn) begin
        if (!resetn) r_irq <= 1'b0;
        else         r_irq <= (w_count_nxt >= c_irq_level) || w_ovr_nxt || w_frm_nxt;
    end

    assign irq = r_irq;
`endif

    assign rx_busy    = (r_count == c_full) ||
                        ((r_state == ST_CAPTURE) && (r_count == c_almost));
    assign host_data  = r_mem[r_rd_ptr];
    assign host_empty = (r_count == '0);
    assign host_count = r_count;
    assign err_ovr    = r_err_ovr;
    assign err_frm    = r_err_frm;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Scoreboard bench for uart_rx_ctrl; pushes expected bytes on good
//            frames, a monitor compares on every accepted host pop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int SIZE  = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic            sample_clock = 1'b0;
    logic            resetn       = 1'b0;
    logic [SIZE-1:0] rx_data      = '0;
    logic            rx_done      = 1'b0;
    logic            rx_err1      = 1'b0;
    logic            rx_err2      = 1'b0;
    logic            rx_busy;
    logic            host_rd      = 1'b0;
    logic [SIZE-1:0] host_data;
    logic            host_empty;
    logic [AW:0]     host_count;
    logic            err_ovr;
    logic            err_frm;
    logic            err_clr      = 1'b0;
`ifdef UART_RXC_IRQ_EN
    logic            irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [SIZE-1:0] sb_q [$];

    uart_rx_ctrl #(
        .SIZE (SIZE),
        .DEPTH(DEPTH),
        .AW   (AW)
`ifdef UART_RXC_IRQ_EN
        ,
        .IRQ_LEVEL(2)
`endif
    ) dut (
        .sample_clock(sample_clock),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_err1     (rx_err1),
        .rx_err2     (rx_err2),
        .rx_busy     (rx_busy),
        .host_rd     (host_rd),
        .host_data   (host_data),
        .host_empty  (host_empty),
        .host_count  (host_count),
        .err_ovr     (err_ovr),
        .err_frm     (err_frm),
`ifdef UART_RXC_IRQ_EN
        .irq         (irq),
`endif
        .err_clr     (err_clr)
    );

    always #5 sample_clock = ~sample_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every accepted pop must present the oldest expected byte
    always @(negedge sample_clock) begin
        if (resetn && host_rd && !host_empty) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_data: got %0h expected none (scoreboard empty)", host_data);
            end else begin
                logic [SIZE-1:0] exp_b;
                exp_b = sb_q.pop_front();
                if (host_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h", host_data, exp_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge sample_clock);
        #1;
    endtask

    // one rx_done cycle; returns just after the edge that ends it
    task automatic done_pulse(input logic [SIZE-1:0] d, input logic e1, input logic e2,
                              input logic clr, input logic rd);
        rx_data = d; rx_err1 = e1; rx_err2 = e2; rx_done = 1'b1; err_clr = clr;
        if (!e1 && !e2) sb_q.push_back(d);
        tick();
        rx_done = 1'b0; rx_err1 = 1'b0; rx_err2 = 1'b0; err_clr = 1'b0;
        host_rd = rd;
    endtask

    task automatic frame(input logic [SIZE-1:0] d, input logic e1, input logic e2);
        done_pulse(d, e1, e2, 1'b0, 1'b0);
        tick();
    endtask

    task automatic pop();
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SIZE-1:0] d;
        #12;
        check("rst_empty", host_empty, 1);
        check("rst_busy",  rx_busy,    0);
        check("rst_count", host_count, 0);
        check("rst_ovr",   err_ovr,    0);
        check("rst_frm",   err_frm,    0);
        check("rst_data",  host_data,  0);
        @(negedge sample_clock);
        resetn = 1'b1;
        tick();

        // single byte, latency two edges
        done_pulse(8'hA5, 0, 0, 0, 0);
        check("lat_empty_capture", host_empty, 1);
        tick();
        check("lat_empty", host_empty, 0);
        check("lat_count", host_count, 1);
        check("lat_data",  host_data,  8'hA5);
        pop();
        check("pop_empty", host_empty, 1);

        // fill to full, then overrun event
        frame(8'h11, 0, 0);
        frame(8'h22, 0, 0);
        frame(8'h33, 0, 0);
        check("busy_at3_idle", rx_busy, 0);
        done_pulse(8'h44, 0, 0, 0, 0);
        check("busy_at3_capture", rx_busy, 1);
        tick();
        check("full_busy",  rx_busy,    1);
        check("full_count", host_count, 4);
        frame(8'h55, 1, 0);
        check("ovr_set",   err_ovr,    1);
        check("ovr_count", host_count, 4);
        repeat (4) pop();
        check("drain_empty", host_empty, 1);
        pop();
        check("pop_from_empty", host_count, 0);

        // framing error, clear vs set precedence
        frame(8'h66, 0, 1);
        check("frm_set",   err_frm,    1);
        check("frm_count", host_count, 0);
        done_pulse(8'h77, 0, 1, 1, 0);
        tick();
        check("frm_set_wins", err_frm, 1);
        check("ovr_cleared",  err_ovr, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("frm_cleared", err_frm, 0);

        // simultaneous capture and pop at count 3 across pointer wrap
        frame(8'h01, 0, 0);
        frame(8'h02, 0, 0);
        frame(8'h03, 0, 0);
        for (int i = 0; i < 10; i++) begin
            d = 8'h80 + 8'(i);
            done_pulse(d, 0, 0, 0, 1);
            tick();
            host_rd = 1'b0;
            check("simul_count", host_count, 3);
        end
        repeat (3) pop();
        check("simul_drain", host_empty, 1);

        // asynchronous reset during capture drops the pending byte
        frame(8'h99, 1, 0);
        check("pre_rst_ovr", err_ovr, 1);
        done_pulse(8'hC3, 0, 0, 0, 0);
        void'(sb_q.pop_back());
        resetn = 1'b0;
        #1;
        check("arst_count", host_count, 0);
        check("arst_ovr",   err_ovr,    0);
        check("arst_empty", host_empty, 1);
        tick();
        resetn = 1'b1;
        tick();
        tick();
        check("arst_nowrite", host_count, 0);
        check("arst_data",    host_data,  0);

`ifdef UART_RXC_IRQ_EN
        check("irq_rst", irq, 0);
        frame(8'hD1, 0, 0);
        check("irq_one", irq, 0);
        frame(8'hD2, 0, 0);
        check("irq_two", irq, 1);
        pop();
        check("irq_after_pop", irq, 0);
        pop();
        frame(8'hD3, 0, 1);
        check("irq_frm", irq, 1);
`endif

        tick();
        check("sb_leftover", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
